// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and halts on an illegal opcode or a memory ack timeout.
//
// state  | meaning
// IDLE   | first cycle after reset, nothing requested
// FETCH  | instruction request outstanding, IR loads on ack
// DECODE | opcode legality check
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | load/store request outstanding, retires on ack
// WB     | register writeback and PC update
// TRAP   | halted until reset, cause held
module rv32i_mc_control #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [31:0]      iInst_Code,
  input  logic             iBtaken,
  input  logic             iInst_Ack,
  input  logic             iData_Ack,
  output logic             oInst_Req,
  output logic             oIR_En,
  output logic             oPC_En,
  output logic [1:0]       oPC_Sel,
  output logic [3:0]       oALU_Control,
  output logic             oALUSrcMuxSel1,
  output logic             oALUSrcMuxSel2,
  output logic [1:0]       oRegWrDataSel,
  output logic             oRegWrEn,
  output logic             oData_RdReq,
  output logic             oData_WrReq,
  output logic [2:0]       oData_Size,
  output logic             oTrap,
  output logic [1:0]       oTrapCause,
  output logic [CNT_W-1:0] oInstret
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW:0] LIMIT = (TW+1)'(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [TW:0]   to_inc;
  logic          timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5, rd_nz;
  logic       is_r, is_i, is_il, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
  logic       legal, in_exu, pc_en;
  logic       unused_inst_bits;

  assign opcode = iInst_Code[6:0];
  assign funct3 = iInst_Code[14:12];
  assign f7b5   = iInst_Code[30];
  assign rd_nz  = |iInst_Code[11:7];
  assign unused_inst_bits = ^{iInst_Code[31], iInst_Code[29:15]};

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_il    = (opcode == 7'b0000011);
  assign is_s     = (opcode == 7'b0100011);
  assign is_b     = (opcode == 7'b1100011);
  assign is_lui   = (opcode == 7'b0110111);
  assign is_auipc = (opcode == 7'b0010111);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign legal    = is_r | is_i | is_il | is_s | is_b | is_lui | is_auipc | is_jal | is_jalr;

  assign to_inc      = {1'b0, to_cnt} + (TW+1)'(1);
  assign timeout_hit = (ACK_TIMEOUT != 0) && (to_inc == LIMIT);

  assign in_exu = (state == EXEC) || (state == MEM) || (state == WB);
  assign pc_en  = ((state == EXEC) && is_b) || ((state == MEM) && iData_Ack) || (state == WB);

  // Ack-cycle strobes are combinational so the datapath captures in the same cycle.
  assign oIR_En         = (state == FETCH) && iInst_Ack;
  assign oPC_En         = pc_en;
  assign oTrap          = (state == TRAP);
  assign oData_Size     = (state == MEM) ? funct3 : 3'b000;
  assign oALUSrcMuxSel1 = in_exu && is_auipc;
  assign oALUSrcMuxSel2 = in_exu && (is_i | is_il | is_s | is_jalr | is_auipc);
  assign oRegWrEn       = ((state == WB) && rd_nz) ||
                          ((state == MEM) && iData_Ack && is_il && rd_nz);

  always_comb begin
    oALU_Control = 4'b0000;
    if (in_exu) begin
      if (is_r)      oALU_Control = {f7b5, funct3};
      else if (is_i) oALU_Control = {(funct3 == 3'b101) & f7b5, funct3};
      else if (is_b) oALU_Control = {1'b0, funct3};
    end
  end

  always_comb begin
    oPC_Sel       = 2'd0;
    oRegWrDataSel = 2'd0;
    if ((state == EXEC) && is_b) begin
      oPC_Sel = iBtaken ? 2'd1 : 2'd0;
    end else if ((state == MEM) && iData_Ack && is_il) begin
      oRegWrDataSel = 2'd1;
    end else if (state == WB) begin
      if (is_lui)                 oRegWrDataSel = 2'd2;
      else if (is_jal || is_jalr) oRegWrDataSel = 2'd3;
      if (is_jal)       oPC_Sel = 2'd1;
      else if (is_jalr) oPC_Sel = 2'd2;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      oInstret    <= '0;
      oTrapCause  <= 2'd0;
      oInst_Req   <= 1'b0;
      oData_RdReq <= 1'b0;
      oData_WrReq <= 1'b0;
    end else begin
      if (pc_en) oInstret <= oInstret + CNT_W'(1);
      case (state)
        IDLE: begin
          state     <= FETCH;
          oInst_Req <= 1'b1;
          to_cnt    <= '0;
        end
        FETCH: begin
          if (iInst_Ack) begin
            state     <= DECODE;
            oInst_Req <= 1'b0;
          end else if (timeout_hit) begin
            state      <= TRAP;
            oTrapCause <= 2'd2;
            oInst_Req  <= 1'b0;
          end else begin
            to_cnt <= to_inc[TW-1:0];
          end
        end
        DECODE: begin
          if (!legal) begin
            state      <= TRAP;
            oTrapCause <= 2'd1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_il || is_s) begin
            state       <= MEM;
            to_cnt      <= '0;
            oData_RdReq <= is_il;
            oData_WrReq <= is_s;
          end else if (is_b) begin
            state     <= FETCH;
            oInst_Req <= 1'b1;
            to_cnt    <= '0;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (iData_Ack) begin
            state       <= FETCH;
            oData_RdReq <= 1'b0;
            oData_WrReq <= 1'b0;
            oInst_Req   <= 1'b1;
            to_cnt      <= '0;
          end else if (timeout_hit) begin
            state       <= TRAP;
            oTrapCause  <= 2'd3;
            oData_RdReq <= 1'b0;
            oData_WrReq <= 1'b0;
          end else begin
            to_cnt <= to_inc[TW-1:0];
          end
        end
        WB: begin
          state     <= FETCH;
          oInst_Req <= 1'b1;
          to_cnt    <= '0;
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
